// File: rtl/atctlc2axi500_burst_split_pkg.sv
// Shared constants and types for the atctlc2axi500 burst splitter.
//   BOUND_BIT     : bit index of the AXI 4 KB boundary
//   AXI_LEN_W     : width of AxLEN
//   MAX_BEATS_LIM : largest legal MAX_BEATS
//   N_W           : width of a per-burst beat count (1..MAX_BEATS_LIM)
package atctlc2axi500_burst_split_pkg;

    localparam int BOUND_BIT     = 12;
    localparam int AXI_LEN_W     = 8;
    localparam int MAX_BEATS_LIM = 256;
    localparam int N_W           = 9;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/atctlc2axi500_burst_calc.sv
// Combinational burst sizing.
//   addr_lo : low 12 bits of the current burst address (bus-aligned)
//   rem     : beats still to issue for the command
//   n       : beats in this burst = min(rem, MAX_BEATS, beats to 4 KB page end)
//   len     : n-1 (AxLEN)
//   last    : this burst finishes the command
module atctlc2axi500_burst_calc
    import atctlc2axi500_burst_split_pkg::*;
#(
    parameter int DATA_BYTES = 8,
    parameter int MAX_BEATS  = 16,
    parameter int LEN_WIDTH  = 12
) (
    input  logic [BOUND_BIT-1:0] addr_lo,
    input  logic [LEN_WIDTH:0]   rem,
    output logic [N_W-1:0]       n,
    output logic [AXI_LEN_W-1:0] len,
    output logic                 last
);
    localparam int OFF   = $clog2(DATA_BYTES);
    localparam int BND_W = BOUND_BIT + 1 - OFF;
    // Common compare width wide enough for rem, bnd and MAX_BEATS.
    localparam int CW    = max2(LEN_WIDTH + 1, BOUND_BIT + 1);
    localparam logic [BOUND_BIT:0] PAGE = {1'b1, {BOUND_BIT{1'b0}}};

    logic [BOUND_BIT:0] bytes_left;
    logic [BND_W-1:0]   bnd;
    logic [CW-1:0]      rem_x, bnd_x, cap_x, n_x;

    always_comb begin
        // addr_lo is bus-aligned, so the shift is an exact division.
        bytes_left = PAGE - {1'b0, addr_lo};
        bnd        = BND_W'(bytes_left >> OFF);
        rem_x      = CW'(rem);
        bnd_x      = CW'(bnd);
        cap_x      = CW'(MAX_BEATS);
        n_x        = rem_x;
        if (cap_x < n_x) n_x = cap_x;
        if (bnd_x < n_x) n_x = bnd_x;
        n    = N_W'(n_x);
        len  = AXI_LEN_W'(n_x - CW'(1));
        last = (n_x == rem_x);
    end

endmodule

// File: rtl/atctlc2axi500_burst_split.sv
// Splits a linear command into AXI bursts capped at MAX_BEATS that never
// cross a 4 KB page.
//   clk, resetn          : AXI clock, async active-low reset
//   cmd_valid/cmd_ready  : command handshake (FIFO rvalid/rready)
//   cmd_addr/beats/id    : start address, beats-1, transaction ID
//   bst_valid/bst_ready  : burst handshake toward the AW/AR driver
//   bst_addr/len/id/last : burst start, AxLEN, ID, final burst of command
//   busy                 : command in progress
module atctlc2axi500_burst_split
    import atctlc2axi500_burst_split_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_BYTES = 8,
    parameter int LEN_WIDTH  = 12,
    parameter int MAX_BEATS  = 16,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_beats,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    output logic                  bst_valid,
    input  logic                  bst_ready,
    output logic [ADDR_WIDTH-1:0] bst_addr,
    output logic [AXI_LEN_W-1:0]  bst_len,
    output logic [ID_WIDTH-1:0]   bst_id,
    output logic                  bst_last,
    output logic                  busy
);
    localparam int OFF   = $clog2(DATA_BYTES);
    localparam int REM_W = LEN_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_BYTES - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;

    logic [N_W-1:0]        n;
    logic [AXI_LEN_W-1:0]  calc_len;
    logic                  calc_last;

    atctlc2axi500_burst_calc #(
        .DATA_BYTES (DATA_BYTES),
        .MAX_BEATS  (MAX_BEATS),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_calc (
        .addr_lo (addr_q[BOUND_BIT-1:0]),
        .rem     (rem_q),
        .n       (n),
        .len     (calc_len),
        .last    (calc_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_BURST;
                    addr_d  = cmd_addr & ALIGN_MASK;
                    rem_d   = REM_W'(cmd_beats) + REM_W'(1);
                    id_d    = cmd_id;
                end
            end
            ST_BURST: begin
                if (bst_ready) begin
                    // Address wraps silently past all-ones.
                    addr_d = addr_q + (ADDR_WIDTH'(n) << OFF);
                    rem_d  = rem_q - REM_W'(n);
                    if (calc_last) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // All bst_* come from registers; len/last are masked in IDLE where
    // rem_q may be 0 and the calc result is meaningless.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE);
        bst_valid = (state_q == ST_BURST);
        busy      = (state_q == ST_BURST);
        bst_addr  = addr_q;
        bst_id    = id_q;
        bst_len   = bst_valid ? calc_len : '0;
        bst_last  = bst_valid & calc_last;
    end

endmodule

// File: tb/tb_atctlc2axi500_burst_split.sv
module tb_atctlc2axi500_burst_split;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [11:0] cmd_beats;
    logic [3:0]  cmd_id;
    logic        bst_valid;
    logic        bst_ready;
    logic [31:0] bst_addr;
    logic [7:0]  bst_len;
    logic [3:0]  bst_id;
    logic        bst_last;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    atctlc2axi500_burst_split #(
        .ADDR_WIDTH (32),
        .DATA_BYTES (8),
        .LEN_WIDTH  (12),
        .MAX_BEATS  (16),
        .ID_WIDTH   (4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_beats (cmd_beats),
        .cmd_id    (cmd_id),
        .bst_valid (bst_valid),
        .bst_ready (bst_ready),
        .bst_addr  (bst_addr),
        .bst_len   (bst_len),
        .bst_id    (bst_id),
        .bst_last  (bst_last),
        .busy      (busy)
    );

    typedef struct packed {
        logic [31:0]      addr;
        logic [11:0]      beats;
        logic [3:0]       id;
        logic [2:0]       nb;
        logic [3:0][31:0] ea;
        logic [3:0][7:0]  el;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT idle; returns one negedge after accept.
    task automatic run_cmd(input logic [31:0] a, input logic [11:0] b, input logic [3:0] id);
        chk("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_beats = b;
        cmd_id    = id;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", {31'b0, cmd_ready}, 32'd0);
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
    endtask

    task automatic expect_burst(input logic [31:0] a, input logic [7:0] l,
                                input logic last, input logic [3:0] id);
        chk("bst_valid", {31'b0, bst_valid}, 32'd1);
        chk("bst_addr", bst_addr, a);
        chk("bst_len", {24'b0, bst_len}, {24'b0, l});
        chk("bst_last", {31'b0, bst_last}, {31'b0, last});
        chk("bst_id", {28'b0, bst_id}, {28'b0, id});
        @(negedge clk);
    endtask

    task automatic expect_idle();
        chk("idle_bst_valid", {31'b0, bst_valid}, 32'd0);
        chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NV; i++) vecs[i] = '0;
        vecs[0].addr = 32'h0000_1000; vecs[0].beats = 12'd7;  vecs[0].id = 4'd1; vecs[0].nb = 3'd1;
        vecs[0].ea[0] = 32'h1000; vecs[0].el[0] = 8'd7;
        vecs[1].addr = 32'h0000_0000; vecs[1].beats = 12'd39; vecs[1].id = 4'd2; vecs[1].nb = 3'd3;
        vecs[1].ea[0] = 32'h000; vecs[1].el[0] = 8'd15;
        vecs[1].ea[1] = 32'h080; vecs[1].el[1] = 8'd15;
        vecs[1].ea[2] = 32'h100; vecs[1].el[2] = 8'd7;
        vecs[2].addr = 32'h0000_0FC0; vecs[2].beats = 12'd15; vecs[2].id = 4'd3; vecs[2].nb = 3'd2;
        vecs[2].ea[0] = 32'h0FC0; vecs[2].el[0] = 8'd7;
        vecs[2].ea[1] = 32'h1000; vecs[2].el[1] = 8'd7;
        vecs[3].addr = 32'hFFFF_FFF8; vecs[3].beats = 12'd1;  vecs[3].id = 4'd4; vecs[3].nb = 3'd2;
        vecs[3].ea[0] = 32'hFFFF_FFF8; vecs[3].el[0] = 8'd0;
        vecs[3].ea[1] = 32'h0000_0000; vecs[3].el[1] = 8'd0;
        vecs[4].addr = 32'h0000_1003; vecs[4].beats = 12'd0;  vecs[4].id = 4'd5; vecs[4].nb = 3'd1;
        vecs[4].ea[0] = 32'h1000; vecs[4].el[0] = 8'd0;
        vecs[5].addr = 32'h0000_0F80; vecs[5].beats = 12'd16; vecs[5].id = 4'd6; vecs[5].nb = 3'd2;
        vecs[5].ea[0] = 32'h0F80; vecs[5].el[0] = 8'd15;
        vecs[5].ea[1] = 32'h1000; vecs[5].el[1] = 8'd0;
        vecs[6].addr = 32'h0000_0FF0; vecs[6].beats = 12'd3;  vecs[6].id = 4'd7; vecs[6].nb = 3'd2;
        vecs[6].ea[0] = 32'h0FF0; vecs[6].el[0] = 8'd1;
        vecs[6].ea[1] = 32'h1000; vecs[6].el[1] = 8'd1;

        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_beats = '0;
        cmd_id    = '0;
        bst_ready = 1'b1;

        #3;
        chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_bst_valid", {31'b0, bst_valid}, 32'd0);
        chk("rst_bst_last", {31'b0, bst_last}, 32'd0);
        chk("rst_bst_addr", bst_addr, 32'd0);
        chk("rst_bst_len", {24'b0, bst_len}, 32'd0);
        chk("rst_bst_id", {28'b0, bst_id}, 32'd0);

        @(negedge clk);
        resetn = 1'b1;

        // Table-driven commands with full-rate bst_ready.
        for (int i = 0; i < NV; i++) begin
            run_cmd(vecs[i].addr, vecs[i].beats, vecs[i].id);
            for (int k = 0; k < int'(vecs[i].nb); k++)
                expect_burst(vecs[i].ea[k], vecs[i].el[k],
                             (k == int'(vecs[i].nb) - 1), vecs[i].id);
            expect_idle();
        end

        // Backpressure on the first burst of the 4 KB split.
        bst_ready = 1'b0;
        run_cmd(32'h0000_0FC0, 12'd15, 4'd5);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", {31'b0, bst_valid}, 32'd1);
            chk("bp_addr", bst_addr, 32'h0FC0);
            chk("bp_len", {24'b0, bst_len}, 32'd7);
            chk("bp_last", {31'b0, bst_last}, 32'd0);
            chk("bp_id", {28'b0, bst_id}, 32'd5);
            chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            chk("bp_busy", {31'b0, busy}, 32'd1);
            @(negedge clk);
        end
        bst_ready = 1'b1;
        expect_burst(32'h0FC0, 8'd7, 1'b0, 4'd5);
        expect_burst(32'h1000, 8'd7, 1'b1, 4'd5);
        expect_idle();

        // Reset during the second burst of the MAX_BEATS split.
        run_cmd(32'h0, 12'd39, 4'd9);
        expect_burst(32'h000, 8'd15, 1'b0, 4'd9);
        chk("mid_addr", bst_addr, 32'h080);
        #2;
        resetn = 1'b0;
        #1;
        chk("mr_bst_valid", {31'b0, bst_valid}, 32'd0);
        chk("mr_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        chk("mr_busy", {31'b0, busy}, 32'd0);
        chk("mr_bst_addr", bst_addr, 32'd0);
        chk("mr_bst_len", {24'b0, bst_len}, 32'd0);
        chk("mr_bst_last", {31'b0, bst_last}, 32'd0);
        chk("mr_bst_id", {28'b0, bst_id}, 32'd0);
        @(negedge clk);
        chk("mr_hold_valid", {31'b0, bst_valid}, 32'd0);
        resetn = 1'b1;
        run_cmd(32'h0000_2000, 12'd3, 4'd2);
        expect_burst(32'h2000, 8'd3, 1'b1, 4'd2);
        for (int c = 0; c < 4; c++) begin
            chk("no_stale_burst", {31'b0, bst_valid}, 32'd0);
            @(negedge clk);
        end
        expect_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
